// File: rtl/dot_acc.sv
// Dot-product accumulator: sums len multiplier products, then holds the result for a
// valid/ready handshake. Define DOT_ACC_SAT_EN to saturate instead of wrap on overflow.
module dot_acc #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  input  logic               done,
  input  logic [2*WIDTH-1:0] ab,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [ACC_W-1:0]   sum,
  output logic               ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;

  logic [ACC_W:0]   add_full;
  logic [ACC_W-1:0] add_res;
  logic             last_prod;

  // One extra bit on the adder exposes the carry that sets ovf.
  always_comb begin
    add_full = {1'b0, acc_q} + {1'b0, ACC_W'(ab)};
`ifdef DOT_ACC_SAT_EN
    add_res  = add_full[ACC_W] ? '1 : add_full[ACC_W-1:0];
`else
    add_res  = add_full[ACC_W-1:0];
`endif
    last_prod = (cnt_q == len_q - LEN_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= len;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= (len == '0) ? StHold : StAcc;
          end
        end
        StAcc: begin
          if (done) begin
            acc_q <= add_res;
            cnt_q <= cnt_q + LEN_W'(1);
            if (add_full[ACC_W]) ovf_q <= 1'b1;
            if (last_prod) state_q <= StHold;
          end
        end
        StHold: begin
          if (sum_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    sum_valid = (state_q == StHold);
    sum       = acc_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_dot_acc.sv
// Randomized and directed bench for dot_acc against a transaction-level model that keeps
// the exact (unbounded) sum and derives wrapped/saturated result and overflow from it.
module tb_dot_acc;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned ACC_W = 10;
  localparam int unsigned LEN_W = 4;
  localparam longint      LIMIT = longint'(1) << ACC_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [LEN_W-1:0]   len = '0;
  logic               busy;
  logic               done = 1'b0;
  logic [2*WIDTH-1:0] ab = '0;
  logic               sum_valid;
  logic               sum_ready = 1'b0;
  logic [ACC_W-1:0]   sum;
  logic               ovf;

  int n_total = 0;
  int n_bad = 0;

  dot_acc #(.WIDTH(WIDTH), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy), .done(done),
    .ab(ab), .sum_valid(sum_valid), .sum_ready(sum_ready), .sum(sum), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 collecting products, 2 presenting result.
  int     m_phase = 0;
  int     m_left = 0;
  longint m_total = 0;

  function automatic longint exp_sum(input longint t);
    if (t < LIMIT) return t;
`ifdef DOT_ACC_SAT_EN
    return LIMIT - 1;
`else
    return t % LIMIT;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      m_total = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_total = 0;
          m_left  = int'(len);
          m_phase = (len == 0) ? 2 : 1;
        end
        1: if (done) begin
          m_total += longint'(ab);
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (sum_ready) m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("sum_valid", 64'(sum_valid), 64'(m_phase == 2));
    chk("sum", 64'(sum), 64'(exp_sum(m_total)));
    chk("ovf", 64'(ovf), 64'(m_total >= LIMIT));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic product(input int v);
    done = 1'b1;
    ab   = (2*WIDTH)'(v);
    tick();
    done = 1'b0;
  endtask

  task automatic handshake;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  initial begin
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(sum_valid), 0);
    chk("rst_sum", 64'(sum), 0);
    chk("rst_ovf", 64'(ovf), 0);
    rst_n = 1'b1;
    tick();

    // basic
    do_start(3);
    product(6);
    product(20);
    product(961);
    chk("basic_valid", 64'(sum_valid), 1);
    chk("basic_sum", 64'(sum), 987);
    chk("basic_ovf", 64'(ovf), 0);
    handshake();
    chk("basic_idle", 64'(busy), 0);

    // backpressure
    do_start(1);
    product(15);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(sum_valid), 1);
      chk("bp_sum", 64'(sum), 15);
      tick();
    end
    handshake();
    chk("bp_idle", 64'(busy), 0);

    // overflow
    do_start(2);
    product(961);
    product(961);
    chk("ovf_flag", 64'(ovf), 1);
`ifdef DOT_ACC_SAT_EN
    chk("ovf_sum", 64'(sum), 1023);
`else
    chk("ovf_sum", 64'(sum), 898);
`endif
    handshake();

    // len = 0 with stray done pulses in HOLD and IDLE
    do_start(0);
    chk("len0_valid", 64'(sum_valid), 1);
    chk("len0_sum", 64'(sum), 0);
    chk("len0_ovf", 64'(ovf), 0);
    product(100);
    product(200);
    chk("len0_hold_sum", 64'(sum), 0);
    handshake();
    product(300);
    chk("len0_idle_sum", 64'(sum), 0);

    // reset mid-operation
    do_start(4);
    product(5);
    product(9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_sum", 64'(sum), 0);
    chk("mid_rst_valid", 64'(sum_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 64'(sum_valid), 0);
    do_start(1);
    product(7);
    chk("post_rst_sum", 64'(sum), 7);
    handshake();

    // gapped done, start while busy ignored
    do_start(2);
    product(3);
    tick();
    start = 1'b1;
    len   = '0;
    tick();
    start = 1'b0;
    tick();
    product(5);
    chk("gap_valid", 64'(sum_valid), 1);
    chk("gap_sum", 64'(sum), 8);
    handshake();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      len       = LEN_W'($urandom_range(0, 6));
      done      = ($urandom_range(0, 1) == 1);
      ab        = ($urandom_range(0, 1) == 1) ? (2*WIDTH)'($urandom) :
                                                (2*WIDTH)'($urandom_range(0, 40));
      sum_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    done  = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dot_acc.md
DOT_ACC -- requirements
Module: dot_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 5, multiplier operand width; product input is 2*WIDTH bits.
REQ-002 SHALL have parameter ACC_W, default 16, accumulator and sum width; ACC_W >= 2*WIDTH.
REQ-003 SHALL have parameter LEN_W, default 4, width of the product-count field.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-007 SHALL have port len  input  LEN_W  number of products to accumulate; captured on accepted start.
REQ-008 SHALL have port busy  output  1  high when not in IDLE.
REQ-009 SHALL have port done  input  1  multiplier result strobe; one product per high cycle.
REQ-010 SHALL have port ab  input  2*WIDTH  multiplier product; valid when done=1.
REQ-011 SHALL have port sum_valid  output  1  result available.
REQ-012 SHALL have port sum_ready  input  1  consumer accepts result.
REQ-013 SHALL have port sum  output  ACC_W  accumulated result.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag for the current accumulation.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, ACC, HOLD.
REQ-016 SHALL in IDLE with start=1: register len, clear accumulator, count and ovf; next state ACC if len!=0, else HOLD with sum=0.
REQ-017 SHALL in ACC, on each cycle with done=1, add zero-extended ab to accumulator and increment count.
REQ-018 SHALL leave ACC for HOLD on the clock edge that accepts the len-th product; sum_valid rises the cycle after that done (latency 1).
REQ-019 SHALL in ACC with done=0 hold accumulator and count; no timeout.
REQ-020 SHALL ignore done in IDLE and HOLD; accumulator is unaffected.
REQ-021 SHALL ignore start outside IDLE; len changes after capture have no effect.
REQ-022 SHALL in HOLD drive sum_valid=1 with sum and ovf stable until sum_valid && sum_ready, then return to IDLE on that edge.
REQ-023 SHALL accept start in the cycle after the handshake (IDLE); no same-cycle HOLD->ACC restart.
REQ-024 SHALL drive sum_valid=0 in IDLE and ACC; sum shows the running accumulator in ACC.
REQ-025 SHALL, when an addition carries out of ACC_W bits, set ovf=1 and keep it set until the next accepted start or reset.

Reset
REQ-026 SHALL on rst_n=0, asynchronously force state IDLE, accumulator=0, count=0, sum=0, sum_valid=0, busy=0, ovf=0.
REQ-027 SHALL abandon any accumulation in progress on reset; no partial result is presented after release.
REQ-028 SHALL ignore start in the first edge after reset release only if rst_n is still low at that edge.

Configuration
REQ-029 SHALL support macro DOT_ACC_SAT_EN: when defined, an overflowing addition saturates the accumulator at 2^ACC_W-1, and later additions keep it there.
REQ-030 SHALL without DOT_ACC_SAT_EN wrap the accumulator modulo 2^ACC_W; ovf behaves identically in both builds.

Verification
REQ-031 SHALL cover basic: len=3, done with ab=6,20,961 -> sum_valid one cycle after third done, sum=987, ovf=0.
REQ-032 SHALL cover backpressure: len=1, ab=15, sum_ready low 5 cycles -> sum=15 held stable for all 5 cycles, IDLE after handshake.
REQ-033 SHALL cover overflow with ACC_W=10, len=2, ab=961,961 -> ovf=1; sum=898 without macro, sum=1023 with DOT_ACC_SAT_EN.
REQ-034 SHALL cover len=0: start -> HOLD next cycle with sum=0, ovf=0; stray done pulses in IDLE/HOLD leave sum unchanged.
REQ-035 SHALL cover reset mid-op: len=4, two products accepted, rst_n low -> all outputs 0 immediately; a new start with len=1, ab=7 gives sum=7.
REQ-036 SHALL cover gapped done: len=2, done pulses 4 cycles apart with ab=3,5 -> sum=8; start asserted while busy is ignored.
